// File: rtl/exe_mul_sequencer_if.sv
// exe_mul_sequencer_if: EXE-stage request and result bundle for the sequential multiplier
interface exe_mul_sequencer_if;
    logic        start;
    logic [31:0] Val_1;
    logic [31:0] Val_Rm;
    logic [3:0]  Dest;
    logic        S;
    logic        flush;
    logic        freeze;
    logic        done;
    logic [31:0] Mul_Res;
    logic [3:0]  Dest_out;
    logic        WB_EN_out;
    logic        S_out;
    logic [3:0]  Status_Bits;
    modport slave (
        input  start, Val_1, Val_Rm, Dest, S, flush,
        output freeze, done, Mul_Res, Dest_out, WB_EN_out, S_out, Status_Bits
    );
    modport master (
        output start, Val_1, Val_Rm, Dest, S, flush,
        input  freeze, done, Mul_Res, Dest_out, WB_EN_out, S_out, Status_Bits
    );
endinterface

// File: rtl/exe_mul_sequencer.sv
// exe_mul_sequencer: 32-cycle shift-add multiplier that stalls the pipeline while it runs
module exe_mul_sequencer (
    input logic                  clk,
    input logic                  rst,
    exe_mul_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  dest_q, dest_d;
    logic        s_q, s_d;
    logic        done_q, done_d;
    // next-state: latch operands in IDLE, shift-add one multiplier bit per RUN cycle
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        s_d     = s_q;
        case (state_q)
            IDLE: if (bus.start && !bus.flush) begin
                a_d     = bus.Val_1;
                b_d     = bus.Val_Rm;
                dest_d  = bus.Dest;
                s_d     = bus.S;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = (bus.Val_1 == '0 || bus.Val_Rm == '0) ? DONE : RUN;
            end
            RUN: if (bus.flush) begin
                state_d = IDLE;
            end else begin
                acc_d   = b_q[0] ? acc_q + a_q : acc_q;
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? DONE : RUN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end
    // state and datapath registers; done is registered so it cannot glitch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            dest_q  <= '0;
            s_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            s_q     <= s_d;
            done_q  <= done_d;
        end
    end
    // freeze must react in the request cycle itself, so it stays combinational
    always_comb begin
        bus.freeze      = (state_q == IDLE && bus.start && !bus.flush) || state_q == RUN;
        bus.done        = done_q;
        bus.WB_EN_out   = done_q;
        bus.S_out       = s_q & done_q;
        bus.Mul_Res     = acc_q;
        bus.Dest_out    = dest_q;
        bus.Status_Bits = {acc_q[31], acc_q == '0, 2'b00};
    end
endmodule

// File: tb/tb_exe_mul_sequencer.sv
// tb_exe_mul_sequencer: directed scoreboard bench for the sequential multiplier
module tb_exe_mul_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exe_mul_sequencer_if bus ();
    exe_mul_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
        logic        s;
        logic [3:0]  dest;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic s, input logic [3:0] d, input int due);
        logic [31:0] p;
        p = a * b;
        return '{p, {p[31], p == 32'd0, 2'b00}, s, d, due};
    endfunction

    // scoreboard: every done pulse must match the oldest pending product at its due cycle
    always @(negedge clk) if (rst) begin
        if (bus.done) begin
            if (sb.size() == 0) chk("unexpected_done", {31'd0, bus.done}, 32'd0);
            else begin
                e_mon = sb.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e_mon.due));
                chk("mul_res", bus.Mul_Res, e_mon.res);
                chk("status_bits", {28'd0, bus.Status_Bits}, {28'd0, e_mon.st});
                chk("s_out", {31'd0, bus.S_out}, {31'd0, e_mon.s});
                chk("dest_out", {28'd0, bus.Dest_out}, {28'd0, e_mon.dest});
                chk("wb_en", {31'd0, bus.WB_EN_out}, 32'd1);
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("missed_done", {31'd0, bus.done}, 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] d,
                      input logic s, input logic fl_done);
        int lat;
        lat = (a != 0 && b != 0) ? 33 : 1;
        bus.start = 1'b1; bus.Val_1 = a; bus.Val_Rm = b; bus.Dest = d; bus.S = s;
        sb.push_back(mk(a, b, s, d, cyc + lat));
        #1;
        chk("c0_freeze", {31'd0, bus.freeze}, 32'd1);
        chk("c0_done", {31'd0, bus.done}, 32'd0);
        tick;
        bus.start = 1'b0; bus.Val_1 = $urandom; bus.Val_Rm = $urandom; bus.Dest = ~d; bus.S = ~s;
        for (int i = 1; i < lat; i++) begin
            #1;
            chk("run_freeze", {31'd0, bus.freeze}, 32'd1);
            chk("run_done", {31'd0, bus.done}, 32'd0);
            tick;
        end
        bus.flush = fl_done;
        #1;
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("done_freeze", {31'd0, bus.freeze}, 32'd0);
        tick;
        bus.flush = 1'b0;
        #1;
        chk("post_done", {31'd0, bus.done}, 32'd0);
        chk("post_s_out", {31'd0, bus.S_out}, 32'd0);
        chk("post_wb_en", {31'd0, bus.WB_EN_out}, 32'd0);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_freeze"}, {31'd0, bus.freeze}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_wb_en"}, {31'd0, bus.WB_EN_out}, 32'd0);
        chk({tag, "_s_out"}, {31'd0, bus.S_out}, 32'd0);
        chk({tag, "_mul_res"}, bus.Mul_Res, 32'd0);
        chk({tag, "_dest_out"}, {28'd0, bus.Dest_out}, 32'd0);
        chk({tag, "_status"}, {28'd0, bus.Status_Bits}, 32'h4);
    endtask

    initial begin
        bus.start = 1'b0; bus.Val_1 = '0; bus.Val_Rm = '0; bus.Dest = '0; bus.S = 1'b0; bus.flush = 1'b0;
        #2;
        reset_outputs("rst_init");
        tick;
        rst = 1'b1;
        #1;
        chk("rel_done", {31'd0, bus.done}, 32'd0);
        tick;

        op(32'd7, 32'd6, 4'h3, 1'b0, 1'b0);
        op(32'hFFFF_FFFF, 32'd2, 4'hC, 1'b1, 1'b1);
        op(32'd0, 32'h1234, 4'h2, 1'b1, 1'b0);

        // flush mid-RUN: no done, then a fresh op from cycle 12
        bus.start = 1'b1; bus.Val_1 = 32'd9; bus.Val_Rm = 32'd9; bus.Dest = 4'h1; bus.S = 1'b1;
        #1;
        chk("fl_c0_freeze", {31'd0, bus.freeze}, 32'd1);
        tick;
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) tick;
        bus.flush = 1'b1;
        #1;
        chk("fl_c10_freeze", {31'd0, bus.freeze}, 32'd1);
        tick;
        bus.flush = 1'b0;
        #1;
        chk("fl_c11_freeze", {31'd0, bus.freeze}, 32'd0);
        chk("fl_c11_done", {31'd0, bus.done}, 32'd0);
        tick;
        op(32'd1000, 32'd3000, 4'h7, 1'b0, 1'b0);

        // reset mid-RUN discards the op; restart right after release
        bus.start = 1'b1; bus.Val_1 = 32'd5; bus.Val_Rm = 32'd9; bus.Dest = 4'hA; bus.S = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 1; i < 20; i++) tick;
        chk("pre_rst_dest", {28'd0, bus.Dest_out}, 32'hA);
        rst = 1'b0;
        #1;
        reset_outputs("rst_mid");
        tick;
        rst = 1'b1;
        #1;
        chk("rel2_done", {31'd0, bus.done}, 32'd0);
        op(32'd12345, 32'd678, 4'h5, 1'b1, 1'b0);

        // start held high: two back-to-back truncating ops, one IDLE cycle between
        bus.start = 1'b1; bus.Val_1 = 32'h10000; bus.Val_Rm = 32'h10000; bus.Dest = 4'h9; bus.S = 1'b1;
        sb.push_back(mk(32'h10000, 32'h10000, 1'b1, 4'h9, cyc + 33));
        sb.push_back(mk(32'h10000, 32'h10000, 1'b1, 4'h9, cyc + 67));
        for (int i = 0; i < 68; i++) begin
            #1;
            chk("b2b_freeze", {31'd0, bus.freeze}, (i == 33 || i == 67) ? 32'd0 : 32'd1);
            chk("b2b_done", {31'd0, bus.done}, (i == 33 || i == 67) ? 32'd1 : 32'd0);
            if (i == 67) bus.start = 1'b0;
            tick;
        end
        #1;
        chk("b2b_end_freeze", {31'd0, bus.freeze}, 32'd0);
        chk("b2b_end_done", {31'd0, bus.done}, 32'd0);

        // flush beats start in IDLE
        bus.start = 1'b1; bus.flush = 1'b1; bus.Val_1 = 32'd3; bus.Val_Rm = 32'd3;
        #1;
        chk("fl_idle_freeze", {31'd0, bus.freeze}, 32'd0);
        tick;
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        chk("fl_idle_stay", {31'd0, bus.freeze}, 32'd0);

        repeat (40) tick;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
